spi_reg_bridge: RTL and testbench
=================================

# spi_reg_bridge

- Sits directly upstream of the PWM peripheral inside the onboarding top module.
- Receives SPI mode-0 write frames from the `ui_in` pins and decodes them into five 8-bit control registers.
- Drives those registers into the PWM/output-enable logic.
- Everything runs in the single system clock domain: SPI pins are oversampled, not used as clocks.

## Interface
Parameters:
- `SYNC_STAGES`, 2: flip-flop depth of the input synchronizers (≥2).
- `MAX_ADDR`, 7'h04: highest writable register address.

Ports:
- `clk`  in  1  system clock. One clock for the whole block.
- `rst_n`  in  1  reset, synchronous, active-low.
- `sclk`  in  1  SPI clock, asynchronous to `clk`.
- `copi`  in  1  SPI controller-out/peripheral-in data, asynchronous.
- `ncs`  in  1  SPI chip select, active-low, asynchronous.
- `cipo`  out  1  SPI peripheral-out data. Present only with readback (see Configuration).
- `cipo_oe`  out  1  output enable for `cipo`.
- `en_reg_out_7_0`  out  8  register 0x00.
- `en_reg_out_15_8`  out  8  register 0x01.
- `en_reg_pwm_7_0`  out  8  register 0x02.
- `en_reg_pwm_15_8`  out  8  register 0x03.
- `pwm_duty_cycle`  out  8  register 0x04.
- `wr_stb`  out  1  one-cycle pulse when a register write commits.

## Operation
- Frame is 16 bits, MSB first:
  - bit15: R/W̄ (1 = write).
  - bits 14:8: address.
  - bits 7:0: data.
- `sclk`, `copi` and `ncs` each pass through `SYNC_STAGES` flops. `sclk` and `ncs` edges are detected on the synchronized values.
- FSM states:
  - IDLE: waits for the synchronized `ncs` falling edge, then clears the bit counter (5 bits) and the shift register and moves to SHIFT.
  - SHIFT: on each synchronized `sclk` rising edge, shifts synchronized `copi` into the LSB of a 16-bit shift register and increments the counter. The counter saturates at 17; a saturated count marks the frame as overlong. On the synchronized `ncs` rising edge, moves to COMMIT.
  - COMMIT: lasts one cycle, then returns to IDLE.
- Write condition in COMMIT: a write occurs only if all of the following hold:
  - count == 16
  - bit15 == 1
  - address ≤ `MAX_ADDR`
- When the write condition holds: the addressed register loads bits 7:0 and `wr_stb` = 1 for that cycle.
- Otherwise (short frame, overlong frame, read frame, out-of-range address):
  - No register changes.
  - `wr_stb` stays 0.
- `sclk` edges while `ncs` is high are ignored.
- An `ncs` falling edge seen in SHIFT (glitch) restarts the frame with the counter cleared.
- `rst_n` low on any `clk` edge, including mid-frame:
  - FSM → IDLE.
  - All registers, the counter and the shift register → 0.
  - `wr_stb`, `cipo` and `cipo_oe` → 0.
  - After reset the bridge waits for a fresh `ncs` falling edge; a partially received frame is discarded.

## Timing
- Reset value of every output is 0.
- Sampling delay: a raw pin change is seen `SYNC_STAGES`+1 `clk` edges later.
- Write latency: the register update and the `wr_stb` pulse occur on the same edge, `SYNC_STAGES`+2 `clk` cycles after the raw `ncs` rise.
- Register outputs are flops. They hold their value between writes.
- Input requirements (the bench must respect these; violations are not detected):
  - `sclk` high and low phases each ≥ `SYNC_STAGES`+2 `clk` periods.
  - `copi` stable from ≥ `SYNC_STAGES`+1 `clk` periods before the `sclk` rise.
  - `ncs` high time between frames ≥ 3 `clk` periods.

## Configuration
- Macro: `SPI_READBACK_EN`.
- Without the macro:
  - Read frames are ignored.
  - `cipo` and `cipo_oe` are tied to 0.
- With the macro, for a read frame (bit15 == 0) with address ≤ `MAX_ADDR`:
  - After the 8th `sclk` rise of the frame, the addressed register is copied into an 8-bit output shifter, `cipo_oe` goes to 1, and `cipo` = shifter MSB.
  - On each following synchronized `sclk` falling edge the shifter shifts left, so data bits 7..0 appear in order.
  - `cipo_oe` returns to 0 on the `ncs` rise and on reset.
- With the macro, for a read frame with address > `MAX_ADDR`:
  - `cipo_oe` is set and `cipo` = 0 for the rest of the frame.
- With the macro, registers are still not modified by read frames.

## Structure
- Shared package `spi_reg_pkg` holds:
  - `FRAME_BITS` = 16.
  - Address localparams `ADDR_EN_OUT_LO` = 0x00 … `ADDR_PWM_DUTY` = 0x04.
  - The FSM state enum `{IDLE, SHIFT, COMMIT}`.
- One sub-module, `spi_sync`: a `SYNC_STAGES`-deep synchronizer with rise/fall pulse outputs.
  - Instantiated once each for `sclk`, `ncs` and `copi`.
  - The edge outputs of the `copi` instance are unused.

## Test plan
- Reset held 5 cycles → all five registers 0x00, `wr_stb` 0, `cipo_oe` 0.
- Frame 0x80F0 → `en_reg_out_7_0` = 0xF0, `wr_stb` pulses exactly once, other registers unchanged.
- Frame 0x8480, then frame 0x8301 → `pwm_duty_cycle` = 0x80 and `en_reg_pwm_15_8` = 0x01.
- Each of the following leaves all registers unchanged and produces no `wr_stb`:
  - Frame 0x8555 (address 5).
  - Frame 0x00AA (read).
  - A 15-bit frame.
  - A 17-bit frame.
- Reset asserted after 9 bits of frame 0x80FF, then frame 0x8133 → `en_reg_out_7_0` = 0x00 and `en_reg_out_15_8` = 0x33.
- With `SPI_READBACK_EN`: write 0x84A5, then read frame 0x0400 → `cipo` shifts out 1,0,1,0,0,1,0,1 on bits 7..0 and `cipo_oe` = 1 only during the data phase.

Source files
------------

// File: rtl/spi_reg_pkg.sv
// Shared constants, register map and FSM state type for the SPI register bridge.
package spi_reg_pkg;

  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned ADDR_W     = 7;
  localparam int unsigned CNT_W      = 5;
  localparam int unsigned CNT_SAT    = FRAME_BITS + 1;
  localparam int unsigned HDR_BITS   = FRAME_BITS - DATA_W;

  localparam logic [ADDR_W-1:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [ADDR_W-1:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [ADDR_W-1:0] ADDR_EN_PWM_LO = 7'h02;
  localparam logic [ADDR_W-1:0] ADDR_EN_PWM_HI = 7'h03;
  localparam logic [ADDR_W-1:0] ADDR_PWM_DUTY  = 7'h04;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer with rise/fall pulses derived from the synchronized level.
module spi_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise_c,
  output logic fall_c
);

  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      prev  <= chain[STAGES-1];
    end
  end

  assign q      = chain[STAGES-1];
  assign rise_c = q & ~prev;
  assign fall_c = ~q & prev;

endmodule

// File: rtl/spi_reg_bridge.sv
// SPI mode-0 write-frame decoder driving five 8-bit control registers.
// Optional readback path enabled by defining SPI_READBACK_EN.
module spi_reg_bridge
  import spi_reg_pkg::*;
#(
  parameter int unsigned       SYNC_STAGES = 2,
  parameter logic [ADDR_W-1:0] MAX_ADDR    = 7'h04
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              copi,
  input  logic              ncs,
  output logic              cipo,
  output logic              cipo_oe,
  output logic [DATA_W-1:0] en_reg_out_7_0,
  output logic [DATA_W-1:0] en_reg_out_15_8,
  output logic [DATA_W-1:0] en_reg_pwm_7_0,
  output logic [DATA_W-1:0] en_reg_pwm_15_8,
  output logic [DATA_W-1:0] pwm_duty_cycle,
  output logic              wr_stb
);

  logic sclk_q, sclk_rise_c, sclk_fall_c;
  logic ncs_q, ncs_rise_c, ncs_fall_c;
  logic copi_q, copi_rise_c, copi_fall_c;

  spi_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .d(sclk), .q(sclk_q), .rise_c(sclk_rise_c), .fall_c(sclk_fall_c)
  );
  spi_sync #(.STAGES(SYNC_STAGES)) u_sync_ncs (
    .clk(clk), .rst_n(rst_n), .d(ncs), .q(ncs_q), .rise_c(ncs_rise_c), .fall_c(ncs_fall_c)
  );
  spi_sync #(.STAGES(SYNC_STAGES)) u_sync_copi (
    .clk(clk), .rst_n(rst_n), .d(copi), .q(copi_q), .rise_c(copi_rise_c), .fall_c(copi_fall_c)
  );

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      cnt;
  logic [FRAME_BITS-1:0] shreg;
  logic [ADDR_W-1:0]     frame_addr_c;
  logic [DATA_W-1:0]     frame_data_c;
  logic                  write_c;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ncs_fall_c) state_nxt = SHIFT;
      SHIFT:   if (ncs_rise_c) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Frame capture; a chip-select fall while shifting restarts the frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt   <= '0;
      shreg <= '0;
    end else if ((state == IDLE || state == SHIFT) && ncs_fall_c) begin
      cnt   <= '0;
      shreg <= '0;
    end else if (state == SHIFT && !ncs_rise_c && sclk_rise_c) begin
      shreg <= {shreg[FRAME_BITS-2:0], copi_q};
      if (cnt != CNT_W'(CNT_SAT)) cnt <= cnt + CNT_W'(1);
    end
  end

  assign frame_addr_c = shreg[FRAME_BITS-2:DATA_W];
  assign frame_data_c = shreg[DATA_W-1:0];
  assign write_c      = (state == COMMIT) && (cnt == CNT_W'(FRAME_BITS)) &&
                        shreg[FRAME_BITS-1] && (frame_addr_c <= MAX_ADDR);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en_reg_out_7_0  <= '0;
      en_reg_out_15_8 <= '0;
      en_reg_pwm_7_0  <= '0;
      en_reg_pwm_15_8 <= '0;
      pwm_duty_cycle  <= '0;
      wr_stb          <= 1'b0;
    end else begin
      wr_stb <= write_c;
      if (write_c) begin
        case (frame_addr_c)
          ADDR_EN_OUT_LO: en_reg_out_7_0  <= frame_data_c;
          ADDR_EN_OUT_HI: en_reg_out_15_8 <= frame_data_c;
          ADDR_EN_PWM_LO: en_reg_pwm_7_0  <= frame_data_c;
          ADDR_EN_PWM_HI: en_reg_pwm_15_8 <= frame_data_c;
          ADDR_PWM_DUTY:  pwm_duty_cycle  <= frame_data_c;
          default: ;
        endcase
      end
    end
  end

`ifdef SPI_READBACK_EN
  logic [DATA_W-1:0]   out_sh;
  logic                oe;
  logic [HDR_BITS-1:0] header_c;
  logic [DATA_W-1:0]   rd_data_c;
  logic                load_c;

  // Header as it will stand once the 8th bit is shifted in.
  assign header_c = {shreg[HDR_BITS-2:0], copi_q};
  assign load_c   = (state == SHIFT) && sclk_rise_c && !ncs_rise_c && !ncs_fall_c &&
                    (cnt == CNT_W'(HDR_BITS - 1)) && !header_c[HDR_BITS-1];

  always_comb begin
    rd_data_c = '0;
    if (header_c[ADDR_W-1:0] <= MAX_ADDR) begin
      case (header_c[ADDR_W-1:0])
        ADDR_EN_OUT_LO: rd_data_c = en_reg_out_7_0;
        ADDR_EN_OUT_HI: rd_data_c = en_reg_out_15_8;
        ADDR_EN_PWM_LO: rd_data_c = en_reg_pwm_7_0;
        ADDR_EN_PWM_HI: rd_data_c = en_reg_pwm_15_8;
        ADDR_PWM_DUTY:  rd_data_c = pwm_duty_cycle;
        default:        rd_data_c = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_sh <= '0;
      oe     <= 1'b0;
    end else if (ncs_rise_c || ncs_fall_c) begin
      out_sh <= '0;
      oe     <= 1'b0;
    end else if (load_c) begin
      out_sh <= rd_data_c;
      oe     <= 1'b1;
    end else if (state == SHIFT && sclk_fall_c && oe) begin
      out_sh <= {out_sh[DATA_W-2:0], 1'b0};
    end
  end

  assign cipo    = out_sh[DATA_W-1];
  assign cipo_oe = oe;

  logic unused_sync;
  assign unused_sync = ^{sclk_q, ncs_q, copi_rise_c, copi_fall_c};
`else
  assign cipo    = 1'b0;
  assign cipo_oe = 1'b0;

  logic unused_sync;
  assign unused_sync = ^{sclk_q, ncs_q, copi_rise_c, copi_fall_c, sclk_fall_c};
`endif

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Scoreboard bench for spi_reg_bridge: frames push expected register snapshots, a monitor checks each wr_stb.
module tb_spi_reg_bridge;

  logic       clk = 1'b0;
  logic       rst_n, sclk, copi, ncs;
  logic       cipo, cipo_oe, wr_stb;
  logic [7:0] r0, r1, r2, r3, r4;

  int checks = 0;
  int errors = 0;
  int wr_seen = 0;

  logic [7:0]  mdl [5];
  logic [39:0] exp_q [$];
  logic        cap_cipo [17];
  logic        cap_oe   [17];

  always #5 clk = ~clk;

  spi_reg_bridge dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .copi(copi), .ncs(ncs),
    .cipo(cipo), .cipo_oe(cipo_oe),
    .en_reg_out_7_0(r0), .en_reg_out_15_8(r1), .en_reg_pwm_7_0(r2),
    .en_reg_pwm_15_8(r3), .pwm_duty_cycle(r4), .wr_stb(wr_stb)
  );

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [39:0] model_snap();
    return {mdl[4], mdl[3], mdl[2], mdl[1], mdl[0]};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 5; i++) mdl[i] = 8'h00;
  endtask

  task automatic check_regs(input string name);
    chk({name, " reg00"}, 40'(r0), 40'(mdl[0]));
    chk({name, " reg01"}, 40'(r1), 40'(mdl[1]));
    chk({name, " reg02"}, 40'(r2), 40'(mdl[2]));
    chk({name, " reg03"}, 40'(r3), 40'(mdl[3]));
    chk({name, " reg04"}, 40'(r4), 40'(mdl[4]));
  endtask

  // Monitor: each wr_stb high sample is one commit and must match the oldest expected snapshot.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && wr_stb === 1'b1) begin
      wr_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_wr_stb: got pulse expected none");
      end else begin
        chk("commit_snapshot", {r4, r3, r2, r1, r0}, exp_q.pop_front());
      end
    end
  end

  // Sends word[nbits-1:0] MSB first; abort_at > 0 asserts reset after that many bits.
  task automatic send_frame(input logic [16:0] word, input int nbits, input int abort_at,
                            input string name);
    int          wr_before;
    logic        exp_wr;
    logic [15:0] f;
    f = word[15:0];
    exp_wr = (nbits == 16) && f[15] && (f[14:8] <= 7'h04) && (abort_at == 0);
    wr_before = wr_seen;
    if (exp_wr) begin
      mdl[f[10:8]] = f[7:0];
      exp_q.push_back(model_snap());
    end
    for (int i = 0; i < 17; i++) begin
      cap_cipo[i] = 1'b0;
      cap_oe[i]   = 1'b0;
    end
    ncs = 1'b0;
    wait_clk(6);
    for (int i = 0; i < nbits; i++) begin
      if (abort_at != 0 && i == abort_at) begin
        rst_n = 1'b0;
        wait_clk(5);
        ncs  = 1'b1;
        sclk = 1'b0;
        copi = 1'b0;
        wait_clk(3);
        rst_n = 1'b1;
        model_clear();
        wait_clk(8);
        check_regs({name, " after_reset"});
        chk({name, " wr_count"}, 40'(wr_seen - wr_before), 40'(0));
        return;
      end
      copi = word[5'(nbits - 1 - i)];
      wait_clk(6);
      sclk = 1'b1;
      wait_clk(5);
      cap_cipo[i] = cipo;
      cap_oe[i]   = cipo_oe;
      wait_clk(1);
      sclk = 1'b0;
    end
    wait_clk(6);
    ncs = 1'b1;
    wait_clk(10);
    check_regs(name);
    chk({name, " wr_count"}, 40'(wr_seen - wr_before), 40'(exp_wr ? 1 : 0));
    chk({name, " cipo_oe_idle"}, 40'(cipo_oe), 40'(0));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    sclk  = 1'b0;
    copi  = 1'b0;
    ncs   = 1'b1;
    model_clear();
    wait_clk(5);
    rst_n = 1'b1;
    wait_clk(2);
    check_regs("reset");
    chk("reset wr_stb", 40'(wr_stb), 40'(0));
    chk("reset cipo_oe", 40'(cipo_oe), 40'(0));

    send_frame(17'h080F0, 16, 0, "wr_addr0_f0");
    send_frame(17'h08480, 16, 0, "wr_addr4_80");
    send_frame(17'h08301, 16, 0, "wr_addr3_01");
    chk("duty_value", 40'(r4), 40'(8'h80));
    chk("pwm_hi_value", 40'(r3), 40'(8'h01));

    send_frame(17'h08555, 16, 0, "addr5_ignored");
    send_frame(17'h000AA, 16, 0, "read_ignored");
`ifndef SPI_READBACK_EN
    for (int i = 0; i < 16; i++) chk("read cipo_oe_tied", 40'(cap_oe[i]), 40'(0));
`endif
    send_frame(17'h04091, 15, 0, "short_frame");
    send_frame(17'h18122, 17, 0, "long_frame");

    send_frame(17'h080FF, 16, 9, "reset_midframe");
    send_frame(17'h08133, 16, 0, "wr_addr1_33");
    chk("out_lo_after_reset", 40'(r0), 40'(8'h00));
    chk("out_hi_value", 40'(r1), 40'(8'h33));

`ifdef SPI_READBACK_EN
    begin
      logic [7:0] rb;
      rb = 8'hA5;
      send_frame(17'h084A5, 16, 0, "wr_addr4_a5");
      send_frame(17'h00400, 16, 0, "readback_addr4");
      for (int k = 0; k < 7; k++) chk("rb header cipo_oe", 40'(cap_oe[k]), 40'(0));
      for (int k = 7; k < 15; k++) begin
        chk("rb data cipo_oe", 40'(cap_oe[k]), 40'(1));
        chk("rb data cipo", 40'(cap_cipo[k]), 40'(rb[3'(14 - k)]));
      end
    end
`endif

    wait_clk(5);
    chk("scoreboard_drained", 40'(exp_q.size()), 40'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
